key_matrix_fifo: RTL and testbench

- Parametrised successor to the fixed 4x2 key scanner.
- Scans a ROWS x COLS matrix on clk_i and debounces whole scan frames.
- Turns each debounced change into a press or release event byte and queues it in a FIFO.
- MCU reads the FIFO over the existing 8-bit cs/rd/wr register bus; a level interrupt signals pending events or overflow.

---
 rtl/key_pkg.sv | 21 ++
 rtl/key_evt_fifo.sv | 46 ++++
 rtl/key_matrix_fifo.sv | 156 +++++++++++++++
 tb/tb_key_matrix_fifo.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: register map, control/status bit positions, event layout and scanner states
package key_pkg;
  localparam logic [7:0] KEY_ADDR_STATUS = 8'h00;
  localparam logic [7:0] KEY_ADDR_DATA   = 8'h01;
  localparam logic [7:0] KEY_ADDR_CTRL   = 8'h02;
  localparam logic [7:0] KEY_ADDR_CMD    = 8'h03;
  localparam int CTRL_SCAN_EN = 0;
  localparam int CTRL_INT_EN  = 1;
  localparam int CTRL_REL_EN  = 2;
  localparam int STAT_OVF = 7;
  localparam int STAT_NE  = 6;
  localparam int EVT_PRESS = 7;
  localparam int EVT_KEY_W = 7;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WALK} scan_state_t;
  function automatic logic [7:0] evt_byte(input logic pressed, input logic [EVT_KEY_W-1:0] key);
    logic [7:0] e;
    e = {1'b0, key};
    e[EVT_PRESS] = pressed;
    return e;
  endfunction
endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: event queue with flush, sticky overflow and same-cycle push/pop
module key_evt_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  // a pop frees a slot for a simultaneous push, and a push feeds a simultaneous pop
  assign do_pop = pop & (~empty | push);
  assign do_push = push & (~full | pop);
  assign dout = empty ? 8'h00 : mem[rptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      wptr <= wptr + AW'(do_push);
      rptr <= rptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      overflow <= overflow | (push & ~do_push);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wptr] <= din;
endmodule

// File: rtl/key_matrix_fifo.sv
// key_matrix_fifo: debounced ROWS x COLS key scanner queuing press/release events
// for an MCU on an asynchronous 8-bit cs/rd/wr register bus.
module key_matrix_fifo #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEB_FRAMES = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mcu_cs_i,
  input  logic            mcu_wr_i,
  input  logic            mcu_rd_i,
  input  logic [7:0]      mcu_addr_i8,
  input  logic [7:0]      mcu_wrdat_i8,
  output logic [7:0]      mcu_rddat_o8,
  output logic            mcu_int_o,
  input  logic [COLS-1:0] key_col_i,
  output logic [ROWS-1:0] key_row_o
);
  import key_pkg::*;
  localparam int N = ROWS * COLS;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(DEB_FRAMES + 1);
  localparam int IW = $clog2(N);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  logic [1:0] cs_sy;
  logic [2:0] rd_sy, wr_sy;
  logic cs_s, rd_s, wr_s, rd_rise, wr_rise, wr_commit, rd_pend, wr_pend;
  logic [7:0] addr_q, data_q, status;
  logic [2:0] ctrl;
  logic int_q, unused_wdat;
  logic push, pop, flush, empty, full, ovf;
  logic [7:0] fifo_dout;
  logic [FW-1:0] count;
  scan_state_t state, state_n;
  logic [RW-1:0] row;
  logic [DW-1:0] div;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0] cur, prev, deb, full_frame;
  logic slot_end, frame_end, walk_go, walk_last;
  assign cs_s = cs_sy[1];
  assign rd_s = rd_sy[1];
  assign wr_s = wr_sy[1];
  assign rd_rise = rd_sy[1] & ~rd_sy[2];
  assign wr_rise = wr_sy[1] & ~wr_sy[2];
  // pending flags tie each strobe edge to a cycle that actually had cs asserted
  assign wr_commit = wr_rise & wr_pend;
  assign pop = rd_rise & rd_pend;
  assign flush = wr_commit & (addr_q == KEY_ADDR_CMD) & data_q[0];
  assign unused_wdat = ^data_q[7:3];
  always_comb begin
    status = {3'b000, 5'(count)};
    status[STAT_OVF] = ovf;
    status[STAT_NE] = ~empty;
  end
  assign mcu_rddat_o8 = (cs_s | rd_s) ? 8'h00 :
                        mcu_addr_i8 == KEY_ADDR_STATUS ? status :
                        mcu_addr_i8 == KEY_ADDR_DATA ? fifo_dout :
                        mcu_addr_i8 == KEY_ADDR_CTRL ? {5'b00000, ctrl} : 8'h00;
  assign mcu_int_o = int_q;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      cs_sy <= '1;
      rd_sy <= '1;
      wr_sy <= '1;
      addr_q <= '0;
      data_q <= '0;
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
      ctrl <= '0;
      int_q <= 1'b0;
    end else begin
      cs_sy <= {cs_sy[0], mcu_cs_i};
      rd_sy <= {rd_sy[1:0], mcu_rd_i};
      wr_sy <= {wr_sy[1:0], mcu_wr_i};
      if (!cs_s && !wr_s) begin
        addr_q <= mcu_addr_i8;
        data_q <= mcu_wrdat_i8;
        wr_pend <= 1'b1;
      end else if (wr_rise) wr_pend <= 1'b0;
      if (!cs_s && !rd_s) rd_pend <= mcu_addr_i8 == KEY_ADDR_DATA;
      else if (rd_rise) rd_pend <= 1'b0;
      if (wr_commit && addr_q == KEY_ADDR_CTRL) ctrl <= data_q[2:0];
      int_q <= ctrl[CTRL_INT_EN] & (~empty | ovf);
    end
  always_comb begin
    full_frame = cur;
    for (int r = 0; r < ROWS; r++)
      if (row == RW'(r)) full_frame[r*COLS +: COLS] = ~key_col_i;
  end
  assign slot_end = state != S_IDLE && div == DW'(SCAN_DIV - 1);
  assign frame_end = slot_end && row == RW'(ROWS - 1);
  assign cnt_n = full_frame != prev ? CW'(1) : cnt == CW'(DEB_FRAMES) ? cnt : cnt + CW'(1);
  assign walk_go = frame_end && cnt_n == CW'(DEB_FRAMES) && full_frame != deb;
  assign walk_last = idx == IW'(N - 1);
  assign push = state == S_WALK && (prev[idx] ^ deb[idx]) && (prev[idx] | ctrl[CTRL_REL_EN]);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    key_row_o = state == S_IDLE ? '1 : ~(ROWS'(1) << row);
    if (!ctrl[CTRL_SCAN_EN]) state_n = S_IDLE;
    else if (state == S_IDLE) state_n = S_SCAN;
    else if (state == S_SCAN && walk_go) state_n = S_WALK;
    else if (state == S_WALK && walk_last) state_n = S_SCAN;
  end
  // the walk finishes long before the next frame end can overwrite prev
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      row <= '0;
      div <= '0;
      idx <= '0;
      cnt <= '0;
      cur <= '0;
      prev <= '0;
      deb <= '0;
    end else if (!ctrl[CTRL_SCAN_EN]) begin
      row <= '0;
      div <= '0;
      idx <= '0;
      cnt <= '0;
      deb <= '0;
    end else if (state != S_IDLE) begin
      div <= slot_end ? '0 : div + DW'(1);
      if (slot_end) begin
        cur <= full_frame;
        row <= frame_end ? '0 : row + RW'(1);
      end
      if (frame_end) begin
        prev <= full_frame;
        cnt <= cnt_n;
      end
      if (state == S_WALK) begin
        deb[idx] <= prev[idx];
        idx <= walk_last ? '0 : idx + IW'(1);
      end
    end
  key_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_i),
    .rst_n(rst_i),
    .push(push),
    .pop(pop),
    .flush(flush),
    .din(evt_byte(prev[idx], EVT_KEY_W'(idx))),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .overflow(ovf),
    .count(count)
  );
endmodule

// File: tb/tb_key_matrix_fifo.sv
// tb_key_matrix_fifo: directed bench driving a 4x4 key model and the MCU bus
module tb_key_matrix_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cs = 1'b1, wr = 1'b1, rd = 1'b1;
  logic [7:0] addr = '0, wdat = '0, rdat;
  logic irq;
  logic [3:0] key_col, key_row;
  logic [15:0] pressed = '0;
  logic [7:0] d;
  int total = 0, bad = 0;

  key_matrix_fifo #(.ROWS(4), .COLS(4), .SCAN_DIV(8), .DEB_FRAMES(4), .FIFO_DEPTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .mcu_cs_i(cs), .mcu_wr_i(wr), .mcu_rd_i(rd),
    .mcu_addr_i8(addr), .mcu_wrdat_i8(wdat), .mcu_rddat_o8(rdat), .mcu_int_o(irq),
    .key_col_i(key_col), .key_row_o(key_row)
  );

  always #10 clk = ~clk;

  always_comb begin
    key_col = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!key_row[r] && pressed[r*4+c]) key_col[c] = 1'b0;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] v);
    addr = a; cs = 1'b0; rd = 1'b0;
    cyc(4);
    v = rdat;
    rd = 1'b1;
    cyc(3);
    cs = 1'b1;
    cyc(2);
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] v);
    addr = a; wdat = v; cs = 1'b0; wr = 1'b0;
    cyc(4);
    wr = 1'b1;
    cyc(3);
    cs = 1'b1;
    cyc(2);
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] v;
    bus_rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic wait_int(input string tag, input int budget);
    int i = 0;
    while (!irq && i < budget) begin
      cyc(1);
      i++;
    end
    chk(tag, 8'(irq), 8'h01);
  endtask

  initial begin
    cyc(3);
    chk("rst_row", 8'(key_row), 8'h0F);
    chk("rst_int", 8'(irq), 8'h00);
    rst = 1'b1;
    cyc(2);
    chk_rd("rst_status", 8'h00, 8'h00);
    chk_rd("rst_data", 8'h01, 8'h00);
    chk_rd("rst_ctrl", 8'h02, 8'h00);
    chk("rst_row_idle", 8'(key_row), 8'h0F);

    // single press of row1/col2
    bus_wr(8'h02, 8'h03);
    chk_rd("ctrl_rb", 8'h02, 8'h03);
    pressed[6] = 1'b1;
    wait_int("press_int", 1500);
    cyc(320);
    chk_rd("press_status", 8'h00, 8'h41);
    chk_rd("press_data", 8'h01, 8'h86);
    chk_rd("press_status_after", 8'h00, 8'h00);
    chk("press_int_drop", 8'(irq), 8'h00);

    // bouncing key never settles for four frames
    for (int i = 0; i < 24; i++) begin
      pressed[9] = ~pressed[9];
      cyc(13);
    end
    pressed[9] = 1'b0;
    cyc(320);
    chk_rd("bounce_status", 8'h00, 8'h00);

    // simultaneous press and release with release events on
    bus_wr(8'h02, 8'h07);
    pressed[0] = 1'b1; pressed[15] = 1'b1;
    wait_int("pair_press_int", 1500);
    cyc(40);
    chk_rd("pair_press_status", 8'h00, 8'h42);
    chk_rd("pair_press_d0", 8'h01, 8'h80);
    chk_rd("pair_press_d1", 8'h01, 8'h8F);
    pressed[0] = 1'b0; pressed[15] = 1'b0;
    wait_int("pair_rel_int", 1500);
    cyc(40);
    chk_rd("pair_rel_status", 8'h00, 8'h42);
    chk_rd("pair_rel_d0", 8'h01, 8'h00);
    chk_rd("pair_rel_d1", 8'h01, 8'h0F);
    chk_rd("pair_empty_data", 8'h01, 8'h00);
    chk_rd("pair_empty_status", 8'h00, 8'h00);

    // nine presses into an eight-entry queue
    bus_wr(8'h02, 8'h03);
    pressed = '0;
    cyc(256);
    chk_rd("quiet_status", 8'h00, 8'h00);
    pressed = 16'h01FF;
    wait_int("ovf_int", 1500);
    cyc(40);
    chk_rd("ovf_status", 8'h00, 8'hC8);
    chk_rd("ovf_oldest", 8'h01, 8'h80);
    chk_rd("ovf_status_pop", 8'h00, 8'hC7);
    bus_wr(8'h03, 8'h01);
    chk_rd("flush_status", 8'h00, 8'h00);
    chk("flush_int", 8'(irq), 8'h00);
    chk_rd("cmd_read", 8'h03, 8'h00);

    // disable scanning with a key held, then re-enable
    pressed = 16'h0020;
    cyc(256);
    chk_rd("hold_status", 8'h00, 8'h00);
    bus_wr(8'h02, 8'h02);
    chk("dis_row", 8'(key_row), 8'h0F);
    cyc(100);
    chk("dis_row_later", 8'(key_row), 8'h0F);
    chk_rd("dis_status", 8'h00, 8'h00);
    bus_wr(8'h02, 8'h03);
    wait_int("reen_int", 1500);
    cyc(20);
    chk_rd("reen_status", 8'h00, 8'h41);
    chk_rd("reen_data", 8'h01, 8'h85);

    // asynchronous reset in the middle of a walk, with a read in progress
    pressed[0] = 1'b1;
    wait_int("walk_int", 1500);
    addr = 8'h00; cs = 1'b0; rd = 1'b0;
    cyc(3);
    chk("walk_status_live", rdat, 8'h41);
    rst = 1'b0;
    #1;
    chk("mid_rst_row", 8'(key_row), 8'h0F);
    chk("mid_rst_rdat", rdat, 8'h00);
    chk("mid_rst_int", 8'(irq), 8'h00);
    cs = 1'b1; rd = 1'b1;
    cyc(2);
    rst = 1'b1;
    cyc(2);
    chk_rd("post_rst_status", 8'h00, 8'h00);
    chk_rd("post_rst_ctrl", 8'h02, 8'h00);
    chk("post_rst_row", 8'(key_row), 8'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
